// File: rtl/player_ctrl.sv
// player_ctrl -- playback sequencer for the music player datapath.
//
// Turns debounced play/next button pulses, keypad song selection and the
// core's song-done indication into a registered play level, the current song
// index and a one-cycle player-restart pulse.
//
// Optional feature: define PLAYER_CTRL_AUTOPLAY_EN to make song_done enter a
// silent gap of GAP_FRAMES frames and then advance to the next song. Without
// it, song_done rewinds the current song and stops.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   play_button   in   one-cycle pulse, toggles play/pause
//   next_button   in   one-cycle pulse, advance to next song
//   keypad_valid  in   one-cycle pulse qualifying keypad_value
//   keypad_value  in   requested song number (4 bits)
//   song_done     in   one-cycle pulse at end of current song
//   new_frame     in   one-cycle frame tick, paces the inter-song gap
//   play          out  1 = core advances notes/samples
//   song          out  current song index
//   reset_player  out  one-cycle pulse, core rewinds to start of song
//   in_gap        out  1 while in the inter-song gap
//
// state   | meaning
// PAUSED  | core halted on current song
// PLAYING | core running
// SWITCH  | one cycle: restart pulse to core, then PLAYING or PAUSED
// GAP     | silence between songs in autoplay, counting new_frame ticks

module player_ctrl #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int GAP_FRAMES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              keypad_valid,
  input  logic [3:0]        keypad_value,
  input  logic              song_done,
  input  logic              new_frame,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player,
  output logic              in_gap
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SWITCH  = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [SONG_W-1:0] song_n;
  logic              resume, resume_n;
  logic              kp_ok;
  logic [SONG_W-1:0] song_inc;

  assign kp_ok    = keypad_valid && (32'(keypad_value) < NUM_SONGS);
  assign song_inc = (song == SONG_W'(NUM_SONGS - 1)) ? '0 : song + SONG_W'(1);

`ifdef PLAYER_CTRL_AUTOPLAY_EN
  logic [7:0] gap_cnt, gap_cnt_n;
`else
  // Frame ticks only pace the autoplay gap.
  logic unused_new_frame;
  assign unused_new_frame = new_frame;
`endif

  always_comb begin
    state_n  = state;
    song_n   = song;
    resume_n = resume;
`ifdef PLAYER_CTRL_AUTOPLAY_EN
    gap_cnt_n = gap_cnt;
`endif
    // Higher-priority events shadow lower ones in the same cycle.
    case (state)
      PAUSED: begin
        if (kp_ok) begin
          song_n   = SONG_W'(keypad_value);
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (next_button) begin
          song_n   = song_inc;
          resume_n = 1'b0;
          state_n  = SWITCH;
        end else if (play_button) begin
          state_n = PLAYING;
        end
      end
      PLAYING: begin
        if (kp_ok) begin
          song_n   = SONG_W'(keypad_value);
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (next_button) begin
          song_n   = song_inc;
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (song_done) begin
`ifdef PLAYER_CTRL_AUTOPLAY_EN
          gap_cnt_n = 8'd0;
          state_n   = GAP;
`else
          resume_n = 1'b0;
          state_n  = SWITCH;
`endif
        end else if (play_button) begin
          state_n = PAUSED;
        end
      end
      SWITCH: begin
        state_n = resume ? PLAYING : PAUSED;
      end
      GAP: begin
`ifdef PLAYER_CTRL_AUTOPLAY_EN
        if (kp_ok) begin
          song_n   = SONG_W'(keypad_value);
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (next_button) begin
          song_n   = song_inc;
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (play_button) begin
          state_n = PAUSED;
        end else if (gap_cnt == 8'(GAP_FRAMES)) begin
          // Compare the registered count so GAP_FRAMES=0 leaves one cycle
          // after entry.
          song_n   = song_inc;
          resume_n = 1'b1;
          state_n  = SWITCH;
        end else if (new_frame) begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
`else
        state_n = PAUSED;
`endif
      end
      default: state_n = PAUSED;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PAUSED;
      song         <= '0;
      resume       <= 1'b0;
      play         <= 1'b0;
      reset_player <= 1'b0;
    end else begin
      state        <= state_n;
      song         <= song_n;
      resume       <= resume_n;
      play         <= (state_n == PLAYING);
      reset_player <= (state_n == SWITCH);
    end
  end

`ifdef PLAYER_CTRL_AUTOPLAY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= 8'd0;
      in_gap  <= 1'b0;
    end else begin
      gap_cnt <= gap_cnt_n;
      in_gap  <= (state_n == GAP);
    end
  end
`else
  assign in_gap = 1'b0;
`endif

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Playback sequencer for the music player datapath. Turns debounced play/next button pulses, keypad song selection and the song-done indication into a registered play level, a current song index and a one-cycle player-restart pulse. Sits between the button/keypad front end and the music player core, and replaces ad-hoc play/next handling inside the core.

## Interface
Parameters:
- NUM_SONGS, 4: number of selectable songs; legal 2..16.
- SONG_W, 2: width of `song`; ≥ clog2(NUM_SONGS).
- GAP_FRAMES, 3: `new_frame` pulses of silence between songs in autoplay; 0..255.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- play_button  in  1  one-cycle debounced pulse; toggles play/pause.
- next_button  in  1  one-cycle debounced pulse; advance to next song.
- keypad_valid  in  1  one-cycle pulse qualifying `keypad_value`.
- keypad_value  in  4  requested song number.
- song_done  in  1  one-cycle pulse from core at end of current song.
- new_frame  in  1  one-cycle frame tick; paces the inter-song gap.
- play  out  1  registered; 1 = core advances notes/samples.
- song  out  SONG_W  registered current song index.
- reset_player  out  1  registered one-cycle pulse; core rewinds to start of `song`.
- in_gap  out  1  registered; 1 while in GAP state.

## Operation
- States: PAUSED, PLAYING, SWITCH, GAP. Register `resume` (1 bit) holds the post-SWITCH target (1 = PLAYING, 0 = PAUSED).
- Event priority within one cycle: valid keypad > next_button > song_done > play_button. Lower-priority events in the same cycle are dropped, not queued.
- Valid keypad: `keypad_valid` and `keypad_value < NUM_SONGS`. Out-of-range values ignored in all states.
- PAUSED: valid keypad → song=keypad_value, resume=1, SWITCH. next → song=(song+1) mod NUM_SONGS, resume=0, SWITCH. play_button → PLAYING. song_done ignored.
- PLAYING: valid keypad → as PAUSED (resume=1). next → song+1 wrap, resume=1, SWITCH. song_done → see Configuration. play_button → PAUSED.
- SWITCH: lasts exactly one cycle; reset_player=1, play=0; all inputs ignored; exits to PLAYING if resume else PAUSED.
- GAP: play=0, in_gap=1; counter cleared on entry, increments on each `new_frame`. Leaves when count reaches GAP_FRAMES → song+1 wrap, resume=1, SWITCH. Keypad or next_button in GAP: handled as in PLAYING (skips remaining gap). play_button in GAP → PAUSED, song unchanged. GAP_FRAMES=0: GAP exits on the cycle after entry.
- Selecting the current song via keypad still passes through SWITCH (restart).
- Song arithmetic: increment modulo NUM_SONGS; NUM_SONGS-1 wraps to 0.

## Timing
- Reset values: state PAUSED, song=0, play=0, reset_player=0, in_gap=0, resume=0, gap counter=0. Reset mid-SWITCH or mid-GAP aborts; no reset_player pulse generated by reset.
- All outputs registered; input event at edge N changes outputs after edge N+1.
- `song` updates on the same edge that enters SWITCH; reset_player high for that one cycle; play rises (if resume) on the following edge. Keypad/next to play=1: 2 cycles.
- play_button: play toggles 1 cycle after pulse.
- new_frame coincident with GAP entry is not counted.

## Configuration
- `PLAYER_CTRL_AUTOPLAY_EN` defined: song_done in PLAYING → GAP, then auto-advance as above.
- Undefined: song_done in PLAYING → song unchanged, resume=0, SWITCH (rewind and stop); GAP unreachable, in_gap tied 0, gap counter removed.

## Test plan
- Reset, then play_button pulse → play=1 two cycles after reset release+pulse, song=0, reset_player never pulses.
- PLAYING song=3 (NUM_SONGS=4), next_button → song=0, reset_player high exactly one cycle, play 0 that cycle, then play=1.
- PAUSED, keypad_value=2 valid → song=2, SWITCH pulse, play=1; keypad_value=9 valid → no change.
- Same cycle keypad_value=1 valid + next_button + play_button, song=0 → song=1, single reset_player pulse, play=1.
- AUTOPLAY_EN, GAP_FRAMES=3, song_done on song=1 → in_gap=1, play=0 for 3 new_frame pulses, then song=2, reset_player pulse, play=1; repeat with next_button mid-gap → immediate advance.
- AUTOPLAY_EN undefined, song_done on song=1 → song=1, reset_player pulse, play=0, in_gap stays 0.
